// File: rtl/sram_rd_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_streamer_if
// Description : Bundle of the command, SRAM read-port and output-stream
//               signals of sram_rd_streamer.
//               master : the streamer side (drives cmd_ready, the SRAM
//                        address/write-enable, the output stream and done)
//               slave  : the environment side (command source, SRAM data,
//                        stream consumer)
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : command handshake
//   sram_we/sram_addr/sram_dout          : SRAM read port
//   out_valid/out_ready/out_data/out_last: output stream
//   done                                 : command-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_rd_streamer_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_addr;
    logic [AW:0]      cmd_len;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_dout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, sram_dout, out_ready,
        output cmd_ready, sram_we, sram_addr, out_valid, out_data, out_last, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, sram_dout, out_ready,
        input  cmd_ready, sram_we, sram_addr, out_valid, out_data, out_last, done
    );
endinterface
`default_nettype wire

// File: rtl/sram_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_streamer
// Description : Read-side sequencer for a single-port synchronous SRAM.
//               Accepts a (start address, beat count) command, issues
//               sequential reads (address wraps modulo DEPTH), absorbs the
//               one-cycle SRAM read latency in a 2-entry skid FIFO and
//               presents the words on a valid/ready stream with full
//               back-pressure. One beat per cycle when never stalled.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               bus        - sram_rd_streamer_if.master (command, SRAM read
//                            port, output stream, done pulse)
//               stall_cnt  - cycles with out_valid & !out_ready since the
//                            last command accept, saturating (only when
//                            SRAM_RD_STALL_CNT_EN is defined)
// Options     : `define SRAM_RD_STALL_CNT_EN to build the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_streamer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SRAM_RD_STALL_CNT_EN
    output logic [31:0]         stall_cnt,
`endif
    sram_rd_streamer_if.master  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0]    c_ST_IDLE  = 2'd0;
    localparam logic [1:0]    c_ST_RUN   = 2'd1;
    localparam logic [1:0]    c_ST_DRAIN = 2'd2;
    localparam logic [AW-1:0] c_ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_REM_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   c_REM_ZERO = '0;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_done_nxt;
    logic             r_done;

    logic [AW-1:0]    r_rptr;           // next address to read
    logic [AW:0]      r_rem;            // reads still to issue
    logic             r_inflight;       // read issued last cycle
    logic             r_inflight_last;  // ... and it was the final beat

    logic [WIDTH-1:0] r_fifo_data [2];
    logic [1:0]       r_fifo_last;
    logic             r_wsel;
    logic             r_rsel;
    logic [1:0]       r_occ;

    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [2:0]       w_occ_after;
    logic             w_drain_empty;
    logic [AW-1:0]    w_rptr_inc;

    assign w_accept   = (r_state == c_ST_IDLE) && bus.cmd_valid;
    assign w_pop      = (r_occ != 2'd0) && bus.out_ready;
    assign w_push     = r_inflight;

    // Occupancy this cycle will leave behind once the in-flight word lands
    // and the head (if popped) leaves; a new read may only be launched if
    // a slot is guaranteed free for it two cycles from now.
    assign w_occ_after = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == c_ST_RUN) && (r_rem != c_REM_ZERO)
                         && (w_occ_after < 3'd2);

    // Everything issued has been delivered once no read is outstanding and
    // the FIFO is either empty or handing over its final entry right now.
    // Leaving DRAIN on that pop lets done/cmd_ready appear the cycle after
    // the last handshake.
    assign w_drain_empty = !r_inflight
                           && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

    assign w_rptr_inc = (r_rptr == c_ADDR_MAX) ? '0 : r_rptr + AW'(1);

    // ------------------------------------------------------------------
    // FSM: next-state / done decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == c_REM_ZERO) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                if ((r_rem == c_REM_ZERO) || (w_issue && (r_rem == c_REM_ONE))) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_empty) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read issue: pointer, remaining count, in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rptr <= bus.cmd_addr;
                r_rem  <= bus.cmd_len;
            end else if (w_issue) begin
                r_rptr <= w_rptr_inc;
                r_rem  <= r_rem - c_REM_ONE;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem == c_REM_ONE);
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid FIFO. The SRAM returns data every cycle; only words
    // that belong to a read issued last cycle are captured.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wsel      <= 1'b0;
            r_rsel      <= 1'b0;
            r_occ       <= 2'd0;
            r_fifo_last <= 2'b00;
        end else begin
            if (w_push) begin
                r_fifo_last[r_wsel] <= r_inflight_last;
                r_wsel              <= ~r_wsel;
            end
            if (w_pop) begin
                r_rsel <= ~r_rsel;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage needs no reset: out_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wsel] <= bus.sram_dout;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready = (r_state == c_ST_IDLE);
    assign bus.sram_we   = 1'b0;
    assign bus.sram_addr = r_rptr;
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_data  = r_fifo_data[r_rsel];
    assign bus.out_last  = (r_occ != 2'd0) && r_fifo_last[r_rsel];
    assign bus.done      = r_done;

`ifdef SRAM_RD_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Stall counter: consumer back-pressure cycles for the current command
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_rd_streamer
// Description : Self-checking bench for sram_rd_streamer. An SRAM model
//               feeds the DUT; a reference model predicts the beat sequence
//               of every command straight from (addr, len) and the memory
//               contents, plus the cycle on which done must pulse.
//               Build with SRAM_RD_STALL_CNT_EN to also check stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_rd_streamer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_rd_streamer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef SRAM_RD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    sram_rd_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SRAM_RD_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    // SRAM model: registered read every cycle
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) bus.sram_dout <= mem[bus.sram_addr];

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode = 0;
    int rdy_ctr  = 0;
    int acc_cyc  = 0;
    int first_valid_cyc = -1;
    int exp_done_cyc    = -1;
    int done_cyc        = -1;
    int done_seen       = 0;
    int stall_model     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1,0,0...
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                bus.out_ready = (rdy_ctr % 3 == 0);
                rdy_ctr++;
            end
        endcase
    end

    // Stream / done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid && !bus.out_ready) stall_model++;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'd1, 64'd0);
            end else begin
                mon_b = exp_q.pop_front();
                chk("beat_data", 64'(bus.out_data), 64'(mon_b.d));
                chk("beat_last", 64'(bus.out_last), 64'(mon_b.l));
                if (mon_b.l) exp_done_cyc = cyc + 1;
            end
        end
        if (bus.done) begin
            done_seen++;
            done_cyc = cyc;
            chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
            chk("ready_at_done", 64'(bus.cmd_ready), 64'd1);
            exp_done_cyc = -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int addr, input int len);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr[AW-1:0];
        bus.cmd_len   = len[AW:0];
        acc_cyc         = cyc;
        first_valid_cyc = -1;
        stall_model     = 0;
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = mem[(addr + i) % DEPTH];
            b.l = (i == len - 1);
            exp_q.push_back(b);
        end
        if (len == 0) exp_done_cyc = cyc + 1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int len);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < 40 * len + 50) begin
            step();
            n++;
        end
        chk("done_seen", 64'(done_seen - d0), 64'd1);
    endtask

    task automatic post_checks();
        step();
        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_no_valid", 64'(bus.out_valid), 64'd0);
        chk("we_low", 64'(bus.sram_we), 64'd0);
`ifdef SRAM_RD_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
    endtask

    task automatic run(input int addr, input int len, input int mode);
        rdy_mode = mode;
        send(addr, len);
        wait_done(len);
        if (mode == 0) begin
            if (len > 0) chk("first_beat_lat", 64'(first_valid_cyc - acc_cyc), 64'd3);
            chk("done_lat", 64'(done_cyc - acc_cyc), 64'((len == 0) ? 1 : len + 3));
        end
        if (len == 0) chk("len0_no_valid", 64'(first_valid_cyc), 64'(-1));
        post_checks();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);

        // Reset values
        rst = 1'b1;
        step();
        step();
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_sram_addr", 64'(bus.sram_addr), 64'd0);
        chk("rst_sram_we",   64'(bus.sram_we),   64'd0);
`ifdef SRAM_RD_STALL_CNT_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;
        step();

        // Directed cases
        run(4, 3, 0);             // 4,5,6 back to back
        run(DEPTH - 2, 4, 0);     // wrap past DEPTH-1
        run(3, 8, 2);             // ready 1,0,0 pattern
        run(7, 0, 0);             // zero-length command
        run(9, DEPTH, 1);         // every address once, wrapping

        // cmd_valid while busy is ignored
        rdy_mode = 0;
        send(2, 6);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 4'd9;
        bus.cmd_len   = 5'd3;
        step();
        step();
        bus.cmd_valid = 1'b0;
        wait_done(6);
        post_checks();

        // Reset two cycles after accepting a long command
        rdy_mode = 0;
        send(5, 16);
        step();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
`ifdef SRAM_RD_STALL_CNT_EN
        chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        run(0, 2, 0);

        // Randomized commands over random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int k = 0; k < 24; k++) begin
            run(int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, DEPTH)),
                int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_rd_streamer.md
# sram_rd_streamer

Read-side sequencer placed directly downstream of the single-port synchronous `sram` buffer. A command selects a start address and beat count, and the block issues sequential reads into the SRAM. It absorbs the SRAM's one-cycle read latency in a 2-entry skid FIFO and presents the words on a valid/ready stream with full back-pressure. Throughput is one beat per cycle when the consumer never stalls.

## Interface
- `WIDTH`, 64: data width; must equal the attached `sram` WIDTH.
- `DEPTH`, 256: SRAM depth; `AW = $clog2(DEPTH)` is derived, not overridable.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_addr` in AW: first SRAM address.
- `cmd_len` in AW+1: beats to read, 0..DEPTH.
- `sram_we` out 1: tied 0; this block never writes.
- `sram_addr` out AW: read address to the SRAM.
- `sram_dout` in WIDTH: SRAM registered read data.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out WIDTH: stream data.
- `out_last` out 1: final beat of the command.
- `done` out 1: one-cycle pulse when the command completes.
- `stall_cnt` out 32: present only with `SRAM_RD_STALL_CNT_EN`.

## Operation
- **States.**
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch addr/len and go to RUN; if len=0, pulse `done` next cycle and stay IDLE.
  - RUN: issue reads until `remaining_issue`=0, then go to DRAIN.
  - DRAIN: wait until in-flight=0 and FIFO empty, then pulse `done` and go to IDLE.
- **Issue rule.** A read issues in a cycle when state=RUN, `remaining_issue`>0 and (fifo_occ + inflight − pop) < 2. Here pop = `out_valid & out_ready`.
  - On issue, `sram_addr` takes the current read pointer; the pointer increments modulo DEPTH, so DEPTH−1 wraps to 0.
  - A one-bit `inflight` flag tracks the read issued last cycle.
- **Capture.** When `inflight`=1, `sram_dout` is written into the FIFO in that cycle. Data returned without `inflight` set is ignored, since the SRAM reads every cycle.
- **FIFO.** 2 entries. `out_valid` = FIFO not empty; `out_data` = head. The issue rule guarantees the FIFO never overflows.
- **Last beat.** `out_last` is stored with each entry and is set on the entry whose beat index = len−1.
- **Commands.** Only one command is in progress at a time; `cmd_valid` outside IDLE is ignored.

## Timing
- **Reset values.** `cmd_ready`=1 (IDLE); `out_valid`, `out_last`, `done`, `stall_cnt`=0; `sram_addr`=0; `sram_we`=0 always. FIFO and `inflight` are cleared.
- **First-beat latency.**
  - Cycle 0: command accepted.
  - Cycle 1: first issue (`sram_addr`=cmd_addr).
  - Cycle 2: `sram_dout` valid, captured.
  - Cycle 3: `out_valid`=1.
- **Throughput.** With `out_ready` held at 1, beats appear on consecutive cycles.
- **Completion.** `done` is asserted the cycle after the handshake of the `out_last` beat; `cmd_ready` returns to 1 in that same cycle.
- **Back-pressure.** While `out_valid & !out_ready`, `out_data` and `out_last` stay stable. Issue stops once occupancy + inflight reaches 2 and resumes in the cycle a pop occurs.
- **Reset mid-operation.** The next cycle is IDLE with the FIFO empty. A read still in flight is discarded. No `done` pulse is generated.
- **len=DEPTH.** Every address is read once, wrapping past DEPTH−1 to reach cmd_addr−1.

## Configuration
- **`SRAM_RD_STALL_CNT_EN` defined:**
  - `stall_cnt` port exists.
  - It increments every cycle with `out_valid & !out_ready`, saturating at 2^32−1.
  - It clears to 0 on command accept and on `rst`.
- **Undefined:** the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Preload mem[i]=i. Command addr=4, len=3, `out_ready`=1 → `out_data` 4,5,6 on cycles 3,4,5; `out_last` on the 6; `done` at cycle 6.
- addr=DEPTH−2, len=4 → data DEPTH−2, DEPTH−1, 0, 1 (wrap-around).
- len=8 with `out_ready` toggling 1,0,0,1… → every word is delivered exactly once, in order, with no loss or duplication. With the macro defined, `stall_cnt` equals the number of cycles with valid=1 and ready=0.
- len=0 → `done` pulses one cycle after accept, `out_valid` never rises, and `cmd_ready` remains 1.
- Assert `rst` two cycles after accepting len=16 → the next cycle shows `out_valid`=0 and `cmd_ready`=1. A new command addr=0, len=2 then returns mem[0], mem[1] only.
- Assert `cmd_valid` during RUN → it is ignored; the in-progress command completes unchanged.
